// File: rtl/obstacle_drive_ctrl_if.sv
// obstacle_drive_ctrl_if: sensor inputs and H-bridge/status outputs of the rover drive controller
interface obstacle_drive_ctrl_if #(
  parameter int NUM_SENSORS = 3
);
  logic enable;
  logic [NUM_SENSORS-1:0] obstacle;
  logic motor_L_forward;
  logic motor_L_backward;
  logic motor_R_forward;
  logic motor_R_backward;
  logic [2:0] state_out;
  logic [NUM_SENSORS-1:0] led;
  modport master (
    output enable, obstacle,
    input motor_L_forward, motor_L_backward, motor_R_forward, motor_R_backward, state_out, led
  );
  modport slave (
    input enable, obstacle,
    output motor_L_forward, motor_L_backward, motor_R_forward, motor_R_backward, state_out, led
  );
endinterface

// File: rtl/obstacle_drive_ctrl.sv
// obstacle_drive_ctrl: debounced obstacle-avoidance manoeuvre FSM with dead-time coast and per-wheel PWM
module obstacle_drive_ctrl #(
  parameter int NUM_SENSORS = 3,
  parameter int PWM_WIDTH = 16,
  parameter int PWM_PERIOD = 1000,
  parameter int DUTY_FWD = 760,
  parameter int DUTY_BACK = 500,
  parameter int DUTY_TURN = 780,
  parameter int DEBOUNCE = 4,
  parameter int DEAD_TIME = 50000,
  parameter int BACK_CYCLES = 25000000,
  parameter int TURN_CYCLES = 20000000
) (
  input logic fpgaclk,
  input logic reset,
  obstacle_drive_ctrl_if.slave bus
);
  localparam int C = NUM_SENSORS / 2;
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int TM1 = DEAD_TIME > BACK_CYCLES ? DEAD_TIME : BACK_CYCLES;
  localparam int TMAX = TM1 > TURN_CYCLES ? TM1 : TURN_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FORWARD = 3'd1,
    COAST = 3'd2,
    BACKWARD = 3'd3,
    TURN_LEFT = 3'd4,
    TURN_RIGHT = 3'd5
  } state_t;
  state_t state, state_nxt, target, target_nxt;
  logic alt, alt_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [PWM_WIDTH-1:0] pwm;
  logic [NUM_SENSORS-1:0] f, led_q;
  logic centre_blk, left_blk, right_blk, done;
  logic on_fwd, on_back, on_turn, lf, lb, rf, rb;
  for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_db
    logic [DW-1:0] cnt;
    logic fb, ld, hit;
    assign hit = bus.obstacle[g] != fb && cnt == DW'(DEBOUNCE - 1);
    assign f[g] = fb;
    assign led_q[g] = ld;
    // count consecutive raw samples disagreeing with the filtered flag; flip when the run is long enough
    always_ff @(posedge fpgaclk or posedge reset)
      if (reset) begin
        cnt <= '0;
        fb <= 1'b0;
        ld <= 1'b1;
      end else begin
        cnt <= (bus.obstacle[g] == fb || hit) ? '0 : cnt + 1'b1;
        fb <= hit ? ~fb : fb;
        ld <= hit ? fb : ~fb;
      end
  end
  assign bus.led = led_q;
  assign bus.state_out = state;
  assign centre_blk = f[C];
  assign right_blk = |f[C-1:0];
  assign left_blk = |f[NUM_SENSORS-1:C+1];
  assign done = timer == '0;
  // free-running PWM counter shared by both wheels, independent of the manoeuvre
  always_ff @(posedge fpgaclk or posedge reset)
    if (reset) pwm <= '0;
    else pwm <= pwm == PWM_WIDTH'(PWM_PERIOD - 1) ? '0 : pwm + 1'b1;
  // state register with manoeuvre timer, latched post-coast target and tie-break toggle
  always_ff @(posedge fpgaclk or posedge reset)
    if (reset) begin
      state <= IDLE;
      target <= IDLE;
      alt <= 1'b0;
      timer <= '0;
    end else begin
      state <= state_nxt;
      target <= target_nxt;
      alt <= alt_nxt;
      timer <= timer_nxt;
    end
  // next-state: every direction change goes through COAST; timer reloads on each state entry
  always_comb begin
    state_nxt = state;
    target_nxt = target;
    alt_nxt = alt;
    if (!bus.enable) state_nxt = IDLE;
    else
      case (state)
        IDLE: begin
          state_nxt = COAST;
          target_nxt = FORWARD;
        end
        FORWARD: if (|f) begin
          state_nxt = COAST;
          target_nxt = centre_blk || (left_blk && right_blk) ? BACKWARD : right_blk ? TURN_LEFT : TURN_RIGHT;
        end
        COAST: if (done) state_nxt = target;
        BACKWARD: if (done) begin
          state_nxt = COAST;
          target_nxt = left_blk && !right_blk ? TURN_RIGHT : right_blk && !left_blk ? TURN_LEFT : alt ? TURN_RIGHT : TURN_LEFT;
          alt_nxt = left_blk == right_blk ? !alt : alt;
        end
        TURN_LEFT, TURN_RIGHT: if (done) begin
          state_nxt = COAST;
          target_nxt = FORWARD;
        end
        default: state_nxt = IDLE;
      endcase
    timer_nxt = state_nxt == state ? (done ? timer : timer - 1'b1) :
                state_nxt == COAST ? TW'(DEAD_TIME - 1) :
                state_nxt == BACKWARD ? TW'(BACK_CYCLES - 1) :
                (state_nxt == TURN_LEFT || state_nxt == TURN_RIGHT) ? TW'(TURN_CYCLES - 1) : '0;
  end
  // bridge drive per state; forward and reverse sets are disjoint per wheel so shoot-through cannot occur
  always_comb begin
    on_fwd = pwm < PWM_WIDTH'(DUTY_FWD);
    on_back = pwm < PWM_WIDTH'(DUTY_BACK);
    on_turn = pwm < PWM_WIDTH'(DUTY_TURN);
    lf = (state == FORWARD && on_fwd) || (state == TURN_RIGHT && on_turn);
    lb = (state == BACKWARD && on_back) || (state == TURN_LEFT && on_turn);
    rf = (state == FORWARD && on_fwd) || (state == TURN_LEFT && on_turn);
    rb = (state == BACKWARD && on_back) || (state == TURN_RIGHT && on_turn);
  end
  // registered bridge outputs; disable clears them on the same edge the FSM drops to IDLE
  always_ff @(posedge fpgaclk or posedge reset)
    if (reset) {bus.motor_L_forward, bus.motor_L_backward, bus.motor_R_forward, bus.motor_R_backward} <= 4'b0;
    else {bus.motor_L_forward, bus.motor_L_backward, bus.motor_R_forward, bus.motor_R_backward} <= bus.enable ? {lf, lb, rf, rb} : 4'b0;
endmodule

// File: tb/tb_obstacle_drive_ctrl.sv
// tb_obstacle_drive_ctrl: directed manoeuvre scenarios checked against a behavioural rover model
module tb_obstacle_drive_ctrl;
  localparam int PER = 10, DF = 7, DBK = 5, DT = 10, DB = 3, DEAD = 4, BACK = 16, TURN = 20;
  logic fpgaclk = 1'b0;
  logic reset = 1'b1;
  int pass_cnt = 0, total_cnt = 0;
  obstacle_drive_ctrl_if #(.NUM_SENSORS(3)) bus();
  obstacle_drive_ctrl #(
    .NUM_SENSORS(3), .PWM_WIDTH(16), .PWM_PERIOD(PER), .DUTY_FWD(DF), .DUTY_BACK(DBK),
    .DUTY_TURN(DT), .DEBOUNCE(DB), .DEAD_TIME(DEAD), .BACK_CYCLES(BACK), .TURN_CYCLES(TURN)
  ) dut (
    .fpgaclk(fpgaclk),
    .reset(reset),
    .bus(bus.slave)
  );
  always #5 fpgaclk = ~fpgaclk;
  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
  endfunction
  // behavioural model: modes 0 idle,1 fwd,2 coast,3 back,4 turn-left,5 turn-right; elapsed counts up
  int cyc, m_mode, m_tgt, m_el;
  logic m_alt;
  logic [2:0] m_f;
  logic [2:0] hist [DB-1];
  logic m_lf, m_lb, m_rf, m_rb;
  function automatic int mode_len(input int m);
    return m == 2 ? DEAD : m == 3 ? BACK : (m == 4 || m == 5) ? TURN : 0;
  endfunction
  always @(posedge fpgaclk or posedge reset) begin : model
    int pwm, nm, du;
    logic on, l, c, r, ok;
    logic [2:0] nf;
    if (reset) begin
      cyc <= 0;
      m_mode <= 0;
      m_tgt <= 0;
      m_el <= 0;
      m_alt <= 1'b0;
      m_f <= '0;
      for (int i = 0; i < DB - 1; i++) hist[i] <= '0;
      {m_lf, m_lb, m_rf, m_rb} <= 4'b0;
    end else begin
      pwm = cyc % PER;
      du = m_mode == 1 ? DF : m_mode == 3 ? DBK : (m_mode == 4 || m_mode == 5) ? DT : 0;
      on = bus.enable && pwm < du;
      m_lf <= on && (m_mode == 1 || m_mode == 5);
      m_lb <= on && (m_mode == 3 || m_mode == 4);
      m_rf <= on && (m_mode == 1 || m_mode == 4);
      m_rb <= on && (m_mode == 3 || m_mode == 5);
      l = m_f[2];
      c = m_f[1];
      r = m_f[0];
      nm = m_mode;
      if (!bus.enable) nm = 0;
      else if (m_mode == 0) begin
        nm = 2;
        m_tgt <= 1;
      end else if (m_mode == 1 && m_f != 3'b0) begin
        nm = 2;
        m_tgt <= (c || (l && r)) ? 3 : r ? 4 : 5;
      end else if (m_mode >= 2 && m_el == mode_len(m_mode)) begin
        nm = m_mode == 2 ? m_tgt : 2;
        if (m_mode == 3) begin
          if (l && !r) m_tgt <= 5;
          else if (r && !l) m_tgt <= 4;
          else begin
            m_tgt <= m_alt ? 5 : 4;
            m_alt <= !m_alt;
          end
        end else if (m_mode != 2) m_tgt <= 1;
      end
      m_el <= nm != m_mode ? 1 : m_el + 1;
      m_mode <= nm;
      cyc <= cyc + 1;
      for (int b = 0; b < 3; b++) begin
        nf[b] = m_f[b];
        ok = bus.obstacle[b] != m_f[b];
        for (int i = 0; i < DB - 1; i++) if (hist[i][b] == m_f[b]) ok = 1'b0;
        if (ok) nf[b] = !m_f[b];
      end
      m_f <= nf;
      hist[0] <= bus.obstacle;
      for (int i = 1; i < DB - 1; i++) hist[i] <= hist[i-1];
    end
  end
  // per-cycle comparison of every DUT output against the model, plus shoot-through guard
  initial forever begin
    @(negedge fpgaclk);
    chk("state", bus.state_out, m_mode);
    chk("led", bus.led, 3'(~m_f));
    chk("motors", {bus.motor_L_forward, bus.motor_L_backward, bus.motor_R_forward, bus.motor_R_backward}, {m_lf, m_lb, m_rf, m_rb});
    chk("mutex_L", bus.motor_L_forward & bus.motor_L_backward, 0);
    chk("mutex_R", bus.motor_R_forward & bus.motor_R_backward, 0);
  end
  task automatic wait_state(input logic [2:0] s, input int budget, input string nm);
    int n = 0;
    while (bus.state_out !== s && n < budget) begin
      n++;
      @(negedge fpgaclk);
    end
    chk(nm, bus.state_out, s);
  endtask
  task automatic run_len(input logic [2:0] s, input string nm, input int exp);
    int n = 0;
    while (bus.state_out === s && n < 100) begin
      n++;
      @(negedge fpgaclk);
    end
    chk(nm, n, exp);
  endtask
  task automatic wait_turn(input string nm, input logic [2:0] exp);
    int n = 0;
    while ((bus.state_out === 3'd2 || bus.state_out === 3'd3) && n < 60) begin
      n++;
      @(negedge fpgaclk);
    end
    chk(nm, bus.state_out, exp);
  endtask
  task automatic duty(input int cycles, output int s_lf, output int s_lb, output int s_rf, output int s_rb);
    s_lf = 0;
    s_lb = 0;
    s_rf = 0;
    s_rb = 0;
    for (int i = 0; i < cycles; i++) begin
      s_lf += int'(bus.motor_L_forward);
      s_lb += int'(bus.motor_L_backward);
      s_rf += int'(bus.motor_R_forward);
      s_rb += int'(bus.motor_R_backward);
      @(negedge fpgaclk);
    end
  endtask
  initial begin
    int a, b, c, d, n4;
    bus.enable = 1'b0;
    bus.obstacle = 3'b000;
    @(negedge fpgaclk);
    chk("reset_state", bus.state_out, 3'd0);
    chk("reset_led", bus.led, 3'b111);
    chk("reset_motors", {bus.motor_L_forward, bus.motor_L_backward, bus.motor_R_forward, bus.motor_R_backward}, 4'b0);
    repeat (2) @(negedge fpgaclk);
    reset = 1'b0;
    @(negedge fpgaclk);
    bus.enable = 1'b1;
    wait_state(3'd2, 5, "start_coast");
    run_len(3'd2, "start_coast_len", DEAD);
    chk("start_forward", bus.state_out, 3'd1);
    @(negedge fpgaclk);
    duty(10, a, b, c, d);
    chk("fwd_L_duty", a, 7);
    chk("fwd_R_duty", c, 7);
    chk("fwd_back_zero", b + d, 0);
    bus.obstacle = 3'b001;
    repeat (2) @(negedge fpgaclk);
    bus.obstacle = 3'b000;
    repeat (5) @(negedge fpgaclk);
    chk("glitch_state", bus.state_out, 3'd1);
    chk("glitch_led", bus.led, 3'b111);
    bus.obstacle = 3'b001;
    wait_state(3'd2, 10, "right_coast");
    bus.obstacle = 3'b000;
    run_len(3'd2, "right_coast_len", DEAD);
    chk("turn_left", bus.state_out, 3'd4);
    n4 = 0;
    a = 0;
    b = 0;
    c = 0;
    d = 0;
    for (int n = 0; n < 60 && bus.state_out !== 3'd1; n++) begin
      if (bus.state_out === 3'd4) n4++;
      a += int'(bus.motor_L_forward);
      b += int'(bus.motor_L_backward);
      c += int'(bus.motor_R_forward);
      d += int'(bus.motor_R_backward);
      @(negedge fpgaclk);
    end
    chk("turn_left_len", n4, TURN);
    chk("turn_left_Lb", b, TURN);
    chk("turn_left_Rf", c, TURN);
    chk("turn_left_other", a + d, 0);
    chk("turn_back_fwd", bus.state_out, 3'd1);
    bus.obstacle = 3'b010;
    wait_state(3'd2, 10, "centre_coast");
    bus.obstacle = 3'b000;
    run_len(3'd2, "centre_coast_len", DEAD);
    chk("backward", bus.state_out, 3'd3);
    @(negedge fpgaclk);
    duty(10, a, b, c, d);
    chk("back_L_duty", b, 5);
    chk("back_R_duty", d, 5);
    chk("back_fwd_zero", a + c, 0);
    wait_turn("alt0_turn_left", 3'd4);
    wait_state(3'd1, 40, "alt0_fwd");
    bus.obstacle = 3'b010;
    wait_state(3'd2, 10, "centre_coast2");
    bus.obstacle = 3'b000;
    wait_state(3'd3, 10, "backward2");
    wait_turn("alt1_turn_right", 3'd5);
    wait_state(3'd1, 40, "alt1_fwd");
    bus.obstacle = 3'b010;
    wait_state(3'd2, 10, "centre_coast3");
    bus.obstacle = 3'b100;
    wait_state(3'd3, 10, "backward3");
    wait_turn("left_override", 3'd5);
    bus.obstacle = 3'b000;
    repeat (5) @(negedge fpgaclk);
    chk("turn_right_drive", {bus.motor_L_forward, bus.motor_L_backward, bus.motor_R_forward, bus.motor_R_backward}, 4'b1001);
    bus.enable = 1'b0;
    @(negedge fpgaclk);
    chk("disable_state", bus.state_out, 3'd0);
    chk("disable_motors", {bus.motor_L_forward, bus.motor_L_backward, bus.motor_R_forward, bus.motor_R_backward}, 4'b0);
    bus.enable = 1'b1;
    wait_state(3'd2, 5, "reenable_coast");
    run_len(3'd2, "reenable_coast_len", DEAD);
    chk("reenable_forward", bus.state_out, 3'd1);
    bus.obstacle = 3'b010;
    wait_state(3'd3, 20, "backward4");
    repeat (5) @(negedge fpgaclk);
    chk("led_blocked", bus.led, 3'b101);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_motors", {bus.motor_L_forward, bus.motor_L_backward, bus.motor_R_forward, bus.motor_R_backward}, 4'b0);
    chk("async_reset_state", bus.state_out, 3'd0);
    chk("async_reset_led", bus.led, 3'b111);
    repeat (2) @(negedge fpgaclk);
    reset = 1'b0;
    repeat (10) @(negedge fpgaclk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
